// File: rtl/dmem_responder_if.sv
// LSU-to-dcache port: request (address, lane-aligned write data, byte enables,
// strobes) from the LSU, raw word read data plus completion handshake back.
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_byte_en;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_rdata_raw;
  logic            mem_ready;
  logic            mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_byte_en, mem_wr_en, mem_rd_en,
    input  mem_rdata_raw, mem_ready, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_byte_en, mem_wr_en, mem_rd_en,
    output mem_rdata_raw, mem_ready, mem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised single-port SRAM model with a wait-state sequencer, standing in
// for the dcache. Define DMEM_RANGE_CHECK_EN to reject accesses outside DEPTH words.
module dmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [2:0]      wait_cnt;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic [AW-1:0]   word_idx;
  logic            req;
  logic            both;
  logic            out_of_range;
  logic            reject;
  logic            accept;
  logic            do_write;
  logic            do_read;

  // Byte offset from the window base; the low two bits are lane select the LSU already applied.
  assign offset       = bus.mem_addr - BASE_ADDR;
  assign word_idx     = offset[AW+1:2];
  assign req          = bus.mem_rd_en | bus.mem_wr_en;
  assign both         = bus.mem_rd_en & bus.mem_wr_en;
  assign out_of_range = RANGE_CHECK && (offset >= SPAN);
  assign reject       = both | out_of_range;
  assign accept       = !reset && (state == IDLE) && req;
  assign do_write     = accept & bus.mem_wr_en & !reject;
  assign do_read      = accept & bus.mem_rd_en & !reject;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 3'd0) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 3'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Response data and error are captured once at acceptance and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= do_read ? mem[word_idx] : 32'd0;
      err_q   <= reject;
    end
  end

  // Storage is deliberately not reset so committed writes survive a reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.mem_ready     = (state == RESP);
    bus.mem_err       = (state == RESP) & err_q;
    bus.mem_rdata_raw = rdata_q;
  end

endmodule
